// File: rtl/gpio_apb_arbiter_pkg.sv
// Shared types and constants for the two-master GPIO APB arbiter.
package gpio_apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // GPIO register map (word addresses on PADDR)
   localparam int MODE      = 0;
   localparam int DIRECTION = 1;
   localparam int OUTPUT    = 2;
   localparam int INPUT     = 3;
   localparam int TR_TYPE   = 4;
   localparam int TR_LVL0   = 5;
   localparam int TR_LVL1   = 6;
   localparam int TR_STAT   = 7;
   localparam int IRQ_EN    = 8;

   localparam int DEF_GPIO_PINS      = 32;
   localparam int DEF_PADDR_SIZE     = 4;
   localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/gpio_apb_arbiter_if.sv
// APB3 bus bundle between the arbiter (master) and the GPIO slave port.
interface gpio_apb_arbiter_if
   import gpio_apb_pkg::*;
#(
   parameter int DW = DEF_GPIO_PINS,
   parameter int AW = DEF_PADDR_SIZE
);
   logic            PSEL;
   logic            PENABLE;
   logic            PWRITE;
   logic [AW-1:0]   PADDR;
   logic [DW-1:0]   PWDATA;
   logic [DW/8-1:0] PSTRB;
   logic            PREADY;
   logic            PSLVERR;
   logic [DW-1:0]   PRDATA;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      input  PREADY, PSLVERR, PRDATA
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      output PREADY, PSLVERR, PRDATA
   );
endinterface

// File: rtl/gpio_apb_arbiter_rr.sv
// Two-way round-robin pick: sole requester wins, ties go to the one that did not go last.
module gpio_rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       valid,
   output logic       winner
);
   always_comb begin
      valid  = |req;
      winner = (req == 2'b11) ? ~last_grant : req[1];
   end
endmodule

// File: rtl/gpio_apb_arbiter.sv
// Round-robin arbiter for two req/done masters onto one APB3 slave port.
// Define GPIO_APB_ARB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYCLES.
module gpio_apb_arbiter
   import gpio_apb_pkg::*;
#(
   parameter int GPIO_PINS      = DEF_GPIO_PINS,
   parameter int PADDR_SIZE     = DEF_PADDR_SIZE,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                   CLK,
   input  logic                   HRESET,

   input  logic                   m0_req,
   input  logic                   m0_write,
   input  logic [PADDR_SIZE-1:0]  m0_addr,
   input  logic [GPIO_PINS-1:0]   m0_wdata,
   input  logic [GPIO_PINS/8-1:0] m0_strb,
   output logic                   m0_done,
   output logic [GPIO_PINS-1:0]   m0_rdata,
   output logic                   m0_err,

   input  logic                   m1_req,
   input  logic                   m1_write,
   input  logic [PADDR_SIZE-1:0]  m1_addr,
   input  logic [GPIO_PINS-1:0]   m1_wdata,
   input  logic [GPIO_PINS/8-1:0] m1_strb,
   output logic                   m1_done,
   output logic [GPIO_PINS-1:0]   m1_rdata,
   output logic                   m1_err,

   output logic                   busy,
   output logic                   grant,

   gpio_apb_arbiter_if.master     apb
);
   localparam int SW = GPIO_PINS / 8;

   apb_state_e state;
   logic       last_grant;

   logic       arb_valid;
   logic       arb_winner;

   gpio_rr_arbiter2 u_rr (
      .req        ({m1_req, m0_req}),
      .last_grant (last_grant),
      .valid      (arb_valid),
      .winner     (arb_winner)
   );

   logic                  sel_write;
   logic [PADDR_SIZE-1:0] sel_addr;
   logic [GPIO_PINS-1:0]  sel_wdata;
   logic [SW-1:0]         sel_strb;

   always_comb begin
      sel_write = arb_winner ? m1_write : m0_write;
      sel_addr  = arb_winner ? m1_addr  : m0_addr;
      sel_wdata = arb_winner ? m1_wdata : m0_wdata;
      sel_strb  = arb_winner ? m1_strb  : m0_strb;
   end

`ifdef GPIO_APB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] to_cnt;
   logic          to_hit;
   assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

   // Completion of the ACCESS phase: slave ready, or (optionally) a stall timeout.
   logic                 fin;
   logic                 fin_err;
   logic [GPIO_PINS-1:0] fin_rdata;

   always_comb begin
      fin       = (state == ACCESS) && apb.PREADY;
      fin_err   = apb.PSLVERR;
      fin_rdata = apb.PWRITE ? '0 : apb.PRDATA;
`ifdef GPIO_APB_ARB_TIMEOUT_EN
      if ((state == ACCESS) && !apb.PREADY && to_hit) begin
         fin       = 1'b1;
         fin_err   = 1'b1;
         fin_rdata = '0;
      end
`endif
   end

   always_ff @(posedge CLK or posedge HRESET) begin
      if (HRESET) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         busy        <= 1'b0;
         grant       <= 1'b0;
         apb.PSEL    <= 1'b0;
         apb.PENABLE <= 1'b0;
         apb.PWRITE  <= 1'b0;
         apb.PADDR   <= '0;
         apb.PWDATA  <= '0;
         apb.PSTRB   <= '0;
         m0_done     <= 1'b0;
         m0_rdata    <= '0;
         m0_err      <= 1'b0;
         m1_done     <= 1'b0;
         m1_rdata    <= '0;
         m1_err      <= 1'b0;
`ifdef GPIO_APB_ARB_TIMEOUT_EN
         to_cnt      <= '0;
`endif
      end else begin
         m0_done <= 1'b0;
         m1_done <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  apb.PSEL   <= 1'b1;
                  apb.PWRITE <= sel_write;
                  apb.PADDR  <= sel_addr;
                  apb.PWDATA <= sel_write ? sel_wdata : '0;
                  apb.PSTRB  <= sel_write ? sel_strb  : '0;
                  grant      <= arb_winner;
                  busy       <= 1'b1;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               apb.PENABLE <= 1'b1;
`ifdef GPIO_APB_ARB_TIMEOUT_EN
               to_cnt      <= '0;
`endif
               state       <= ACCESS;
            end
            ACCESS: begin
               if (fin) begin
                  if (grant) begin
                     m1_done  <= 1'b1;
                     m1_rdata <= fin_rdata;
                     m1_err   <= fin_err;
                  end else begin
                     m0_done  <= 1'b1;
                     m0_rdata <= fin_rdata;
                     m0_err   <= fin_err;
                  end
                  apb.PSEL    <= 1'b0;
                  apb.PENABLE <= 1'b0;
                  busy        <= 1'b0;
                  last_grant  <= grant;
                  state       <= IDLE;
               end
`ifdef GPIO_APB_ARB_TIMEOUT_EN
               else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Directed self-checking bench for gpio_apb_arbiter with a small GPIO register-file slave.
`timescale 1ns/1ps
module tb_gpio_apb_arbiter;
   import gpio_apb_pkg::*;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int SW = DW / 8;

   logic CLK = 1'b0;
   logic HRESET = 1'b1;
   always #5 CLK = ~CLK;

   logic          m0_req = 0, m0_write = 0, m1_req = 0, m1_write = 0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
   logic [SW-1:0] m0_strb = '0, m1_strb = '0;
   logic          m0_done, m1_done, m0_err, m1_err, busy, grant;
   logic [DW-1:0] m0_rdata, m1_rdata;

   gpio_apb_arbiter_if #(.DW(DW), .AW(AW)) apb ();

   gpio_apb_arbiter #(.GPIO_PINS(DW), .PADDR_SIZE(AW), .TIMEOUT_CYCLES(16)) dut (
      .CLK(CLK), .HRESET(HRESET),
      .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_strb(m0_strb), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_strb(m1_strb), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .busy(busy), .grant(grant), .apb(apb)
   );

   // Slave: 16-word register file, reset to byte-replicated address; optional PRDATA override
   logic          pready = 1'b1, pslverr = 1'b0, ovr = 1'b0;
   logic [DW-1:0] ovr_data = '0;
   logic [DW-1:0] regs [16];

   assign apb.PREADY  = pready;
   assign apb.PSLVERR = pslverr;
   assign apb.PRDATA  = ovr ? ovr_data : regs[apb.PADDR];

   always @(posedge CLK or posedge HRESET) begin
      if (HRESET) begin
         for (int i = 0; i < 16; i++) regs[i] <= {4{8'(i)}};
      end else if (apb.PSEL && apb.PENABLE && apb.PREADY && apb.PWRITE) begin
         for (int b = 0; b < SW; b++)
            if (apb.PSTRB[b]) regs[apb.PADDR][b*8 +: 8] <= apb.PWDATA[b*8 +: 8];
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      tick();
      tick();
      checks++;
      if ({apb.PSEL, apb.PENABLE, apb.PWRITE, busy, grant, m0_done, m1_done, m0_err, m1_err} !== 9'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=0",
                  {apb.PSEL, apb.PENABLE, apb.PWRITE, busy, grant, m0_done, m1_done, m0_err, m1_err});
      end
      checks++;
      if ({m0_rdata, m1_rdata, apb.PADDR, apb.PWDATA, apb.PSTRB} !== '0) begin
         errors++;
         $display("FAIL reset_data got m0_rdata=%h m1_rdata=%h paddr=%h pwdata=%h pstrb=%h exp all 0",
                  m0_rdata, m1_rdata, apb.PADDR, apb.PWDATA, apb.PSTRB);
      end
      HRESET = 1'b0;
      tick();
   endtask

   task automatic test_tie();
      int ndone = 0, cyc = 0, overlap = 0, wide = 0;
      logic prev = 1'b0;
      m0_write = 0; m0_addr = 4'd2;
      m1_write = 0; m1_addr = 4'd1;
      m0_req = 1; m1_req = 1;
      while (ndone < 4 && cyc < 60) begin
         tick();
         cyc++;
         if (busy && !grant && m1_done) overlap++;
         if (m0_done && m1_done) overlap++;
         if ((m0_done || m1_done) && prev) wide++;
         prev = m0_done || m1_done;
         if (m0_done || m1_done) begin
            checks++;
            if (m1_done !== 1'(ndone % 2)) begin
               errors++;
               $display("FAIL tie_order idx=%0d got m1_done=%b exp=%b", ndone, m1_done, 1'(ndone % 2));
            end
            checks++;
            if (m0_done && m0_rdata !== 32'h0202_0202) begin
               errors++;
               $display("FAIL tie_m0_rdata got=%h exp=02020202", m0_rdata);
            end else if (m1_done && m1_rdata !== 32'h0101_0101) begin
               errors++;
               $display("FAIL tie_m1_rdata got=%h exp=01010101", m1_rdata);
            end
            ndone++;
            if (ndone == 4) begin
               m0_req = 0; m1_req = 0;
            end
         end
      end
      checks++;
      if (ndone !== 4) begin
         errors++;
         $display("FAIL tie_count got=%0d exp=4", ndone);
      end
      checks++;
      if (overlap !== 0) begin
         errors++;
         $display("FAIL tie_overlap got=%0d exp=0", overlap);
      end
      checks++;
      if (wide !== 0) begin
         errors++;
         $display("FAIL tie_done_width got=%0d exp=0", wide);
      end
      m0_req = 0; m1_req = 0;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL tie_idle got busy=%b exp=0", busy);
      end
   endtask

   task automatic test_write();
      int n = 0;
      m0_write = 1; m0_addr = 4'(DIRECTION); m0_wdata = 32'hA5A5_0F0F; m0_strb = 4'hF;
      m0_req = 1;
      tick();
      checks++;
      if ({apb.PSEL, apb.PENABLE, apb.PWRITE, busy, grant, apb.PADDR, apb.PWDATA, apb.PSTRB} !==
          {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'hA5A5_0F0F, 4'hF}) begin
         errors++;
         $display("FAIL wr_setup got sel=%b en=%b wr=%b busy=%b gnt=%b addr=%h wd=%h st=%h exp 1 0 1 1 0 1 a5a50f0f f",
                  apb.PSEL, apb.PENABLE, apb.PWRITE, busy, grant, apb.PADDR, apb.PWDATA, apb.PSTRB);
      end
      tick();
      checks++;
      if ({apb.PSEL, apb.PENABLE, m0_done} !== 3'b110) begin
         errors++;
         $display("FAIL wr_access got sel/en/done=%b exp=110", {apb.PSEL, apb.PENABLE, m0_done});
      end
      tick();
      checks++;
      if ({m0_done, m0_err, m1_done, apb.PSEL, apb.PENABLE, busy, m0_rdata} !== {6'b100000, 32'h0}) begin
         errors++;
         $display("FAIL wr_done got done=%b err=%b m1_done=%b sel=%b en=%b busy=%b rdata=%h exp 1 0 0 0 0 0 0",
                  m0_done, m0_err, m1_done, apb.PSEL, apb.PENABLE, busy, m0_rdata);
      end
      m0_req = 0;
      tick();
      checks++;
      if (m0_done !== 1'b0 || regs[1] !== 32'hA5A5_0F0F) begin
         errors++;
         $display("FAIL wr_once got done=%b reg=%h exp done=0 reg=a5a50f0f", m0_done, regs[1]);
      end
      m0_write = 0; m0_wdata = '0; m0_strb = '0;
      m0_req = 1;
      while (!m0_done && n < 10) begin tick(); n++; end
      m0_req = 0;
      checks++;
      if (m0_done !== 1'b1 || m0_rdata !== 32'hA5A5_0F0F) begin
         errors++;
         $display("FAIL wr_readback got done=%b rdata=%h exp done=1 rdata=a5a50f0f", m0_done, m0_rdata);
      end
      tick();
   endtask

   task automatic test_wait();
      m0_write = 0; m0_addr = 4'(INPUT);
      ovr = 1; ovr_data = 32'h1234_5678; pready = 0;
      m0_req = 1;
      tick();
      tick();
      checks++;
      if ({apb.PSEL, apb.PENABLE, apb.PWDATA, apb.PSTRB} !== {2'b11, 32'h0, 4'h0}) begin
         errors++;
         $display("FAIL wait_enter got sel=%b en=%b wd=%h st=%h exp 1 1 0 0",
                  apb.PSEL, apb.PENABLE, apb.PWDATA, apb.PSTRB);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, m0_done} !== {3'b110, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL wait_stable cyc=%0d got sel=%b en=%b wr=%b addr=%h done=%b exp 1 1 0 3 0",
                     i, apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, m0_done);
         end
      end
      pready = 1;
      tick();
      checks++;
      if (m0_done !== 1'b1 || m0_rdata !== 32'h1234_5678 || m0_err !== 1'b0) begin
         errors++;
         $display("FAIL wait_done got done=%b rdata=%h err=%b exp 1 12345678 0", m0_done, m0_rdata, m0_err);
      end
      m0_req = 0; ovr = 0;
      tick();
   endtask

   task automatic test_slverr();
      int n = 0;
      m1_write = 1; m1_addr = 4'd15; m1_wdata = 32'hDEAD_BEEF; m1_strb = 4'h3;
      pslverr = 1;
      m1_req = 1;
      while (!(m1_done || m0_done) && n < 10) begin tick(); n++; end
      checks++;
      if ({m1_done, m1_err, m0_done} !== 3'b110 || m1_rdata !== 32'h0) begin
         errors++;
         $display("FAIL slverr_m1 got done=%b err=%b m0_done=%b rdata=%h exp 1 1 0 0",
                  m1_done, m1_err, m0_done, m1_rdata);
      end
      checks++;
      if (m0_rdata !== 32'h1234_5678 || m0_err !== 1'b0) begin
         errors++;
         $display("FAIL slverr_m0_hold got rdata=%h err=%b exp 12345678 0", m0_rdata, m0_err);
      end
      m1_req = 0; pslverr = 0; m1_write = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      int n = 0;
      logic first_m0, first_m1;
      m0_write = 0; m0_addr = 4'(MODE);
      m0_req = 1;
      while (!m0_done && n < 10) begin tick(); n++; end
      m0_req = 0;
      tick();
      m1_write = 0; m1_addr = 4'(TR_TYPE);
      pready = 0;
      m1_req = 1;
      tick();
      tick();
      tick();
      checks++;
      if ({busy, grant, apb.PENABLE} !== 3'b111) begin
         errors++;
         $display("FAIL rst_mid_pre got busy/gnt/en=%b exp=111", {busy, grant, apb.PENABLE});
      end
      m0_addr = 4'(TR_LVL0);
      m0_req = 1;
      #2 HRESET = 1;
      #1;
      checks++;
      if ({apb.PSEL, apb.PENABLE, busy, m0_done, m1_done} !== 5'b0) begin
         errors++;
         $display("FAIL rst_mid_async got sel/en/busy/d0/d1=%b exp=0",
                  {apb.PSEL, apb.PENABLE, busy, m0_done, m1_done});
      end
      tick();
      HRESET = 0;
      pready = 1;
      n = 0;
      while (!(m0_done || m1_done) && n < 10) begin tick(); n++; end
      first_m0 = m0_done;
      first_m1 = m1_done;
      m0_req = 0;
      checks++;
      if ({first_m0, first_m1} !== 2'b10 || m0_rdata !== 32'h0505_0505) begin
         errors++;
         $display("FAIL rst_mid_tie got d0=%b d1=%b rdata=%h exp 1 0 05050505", first_m0, first_m1, m0_rdata);
      end
      n = 0;
      tick();
      while (!m1_done && n < 10) begin tick(); n++; end
      m1_req = 0;
      checks++;
      if (m1_done !== 1'b1 || m1_rdata !== 32'h0404_0404) begin
         errors++;
         $display("FAIL rst_mid_m1 got done=%b rdata=%h exp 1 04040404", m1_done, m1_rdata);
      end
      tick();
   endtask

   task automatic test_stall();
      int early = 0, n = 0;
      m0_write = 0; m0_addr = 4'(TR_LVL1);
      ovr = 1; ovr_data = 32'hCAFE_F00D; pready = 0;
      m0_req = 1;
      tick();
      tick();
`ifdef GPIO_APB_ARB_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         tick();
         if (m0_done) early++;
      end
      checks++;
      if (early !== 0) begin
         errors++;
         $display("FAIL to_early got=%0d exp=0", early);
      end
      tick();
      checks++;
      if ({m0_done, m0_err, apb.PSEL, apb.PENABLE, busy} !== 5'b11000 || m0_rdata !== 32'h0) begin
         errors++;
         $display("FAIL to_abort got done=%b err=%b sel=%b en=%b busy=%b rdata=%h exp 1 1 0 0 0 0",
                  m0_done, m0_err, apb.PSEL, apb.PENABLE, busy, m0_rdata);
      end
      m0_req = 0; ovr = 0; pready = 1;
      tick();
      m0_req = 1;
      while (!m0_done && n < 10) begin tick(); n++; end
      m0_req = 0;
      checks++;
      if (m0_done !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'h0606_0606) begin
         errors++;
         $display("FAIL to_recover got done=%b err=%b rdata=%h exp 1 0 06060606", m0_done, m0_err, m0_rdata);
      end
`else
      for (int i = 0; i < 20; i++) begin
         tick();
         if (m0_done || !apb.PSEL) early++;
      end
      checks++;
      if (early !== 0) begin
         errors++;
         $display("FAIL stall_hold got=%0d exp=0", early);
      end
      pready = 1;
      tick();
      m0_req = 0;
      checks++;
      if (m0_done !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL stall_done got done=%b err=%b rdata=%h exp 1 0 cafef00d", m0_done, m0_err, m0_rdata);
      end
      ovr = 0;
`endif
      tick();
   endtask

   initial begin
      test_reset();
      test_tie();
      test_write();
      test_wait();
      test_slverr();
      test_reset_mid();
      test_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule

// File: doc/gpio_apb_arbiter.md
Name: gpio_apb_arbiter

Overview:
- Two-master arbiter and APB3 master that shares the single APB slave port of the GPIO block.
- Each requester (e.g. CPU bridge and a boot-time config sequencer) presents a simple req/done transaction interface.
- The block arbitrates round-robin, then drives one APB SETUP→ACCESS transfer at a time and returns PRDATA/PSLVERR to the winner.

Parameters:
- GPIO_PINS, 32, APB data width; must be a multiple of 8.
- PADDR_SIZE, 4, APB address width.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait cycles; only used when GPIO_APB_ARB_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  clock; all flops rise-edge.
- HRESET  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1 each  transaction request; hold high until done.
- m0_write, m1_write  in  1 each  1=write, 0=read.
- m0_addr, m1_addr  in  PADDR_SIZE each  register address.
- m0_wdata, m1_wdata  in  GPIO_PINS each  write data.
- m0_strb, m1_strb  in  GPIO_PINS/8 each  byte strobes.
- m0_done, m1_done  out  1 each  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  GPIO_PINS each  read data; valid while done is high.
- m0_err, m1_err  out  1 each  PSLVERR (or timeout) status; valid with done.
- busy  out  1  transaction in progress.
- grant  out  1  owner index of the current/last transaction.
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
- PADDR  out  PADDR_SIZE  APB address.
- PWDATA  out  GPIO_PINS  APB write data.
- PSTRB  out  GPIO_PINS/8  APB strobes.
- PREADY, PSLVERR  in  1 each  APB slave response.
- PRDATA  in  GPIO_PINS  APB read data.

Behaviour:
- All outputs are registered.
- Reset values: every output 0; state IDLE; last_grant=1, so m0 wins the first tie.
- FSM IDLE:
  - If any req is sampled high, select a winner: the sole requester, or on a tie the one ≠ last_grant.
  - Latch the winner's write/addr/wdata/strb into PWRITE/PADDR/PWDATA/PSTRB.
  - Set PSEL=1, grant=winner, busy=1; go to SETUP.
- FSM SETUP: PENABLE=1; go to ACCESS unconditionally.
- FSM ACCESS:
  - While PREADY=0, hold all APB outputs stable.
  - On PREADY=1: capture PRDATA into mX_rdata, PSLVERR into mX_err, and pulse mX_done=1 for one cycle on the winner only.
  - In the same cycle: PSEL=PENABLE=0, busy=0, last_grant=winner; go to IDLE.
- Zero-wait latency:
  - req sampled at edge N → PSEL high after N.
  - PENABLE high after N+1.
  - PREADY sampled at N+2 → done high during the cycle after N+2.
  - Earliest next grant is at edge N+3, so there is at least one idle APB cycle between transfers.
- Read data:
  - rdata/err hold their value until the next completion for that master.
  - For writes, rdata is 0.
- Requester fields are sampled only at grant; later changes and req deassertion mid-transfer are ignored, and the transfer completes normally.
- A requester whose req is still high at the IDLE edge after its done starts a new transaction.
- When both requesters are continuously requesting, transfers alternate strictly m0, m1, m0, …
- PWDATA and PSTRB are driven to 0 on reads.
- HRESET asserted mid-transfer: PSEL/PENABLE drop immediately (asynchronously), no done is issued, and the FSM returns to IDLE.

Optional Feature:
- Macro: GPIO_APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES, the transfer is aborted: done=1, err=1, rdata=0, PSEL/PENABLE=0, return to IDLE.
  - If PREADY=1 arrives in the same cycle as expiry, PREADY wins and the transfer completes normally.
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package gpio_apb_pkg contains:
  - FSM state typedef (IDLE, SETUP, ACCESS).
  - GPIO register address constants: MODE=0, DIRECTION=1, OUTPUT=2, INPUT=3, TR_TYPE=4, TR_LVL0=5, TR_LVL1=6, TR_STAT=7, IRQ_EN=8.
  - Default width constants.
- Sub-module gpio_rr_arbiter2 (combinational): inputs req[1:0] and last_grant; outputs valid and winner.

Test Plan:
- m0 write: addr=1, wdata=32'hA5A5_0F0F, strb=4'hF; PREADY tied 1 → PSEL rises 1 cycle after req, PENABLE 1 cycle later, m0_done pulses exactly once, m0_err=0, GPIO DIRECTION reads back 32'hA5A5_0F0F.
- Simultaneous m0/m1 reads of addr 2 and 1 held for 4 transactions → grant order 0,1,0,1; each done is one cycle wide; m1_done is never asserted during an m0 transfer.
- Wait states: PREADY low for 5 ACCESS cycles, slave returns PRDATA=32'h1234_5678 → PADDR/PWRITE/PSEL/PENABLE stable for all 5 cycles; done follows the PREADY cycle; m0_rdata=32'h1234_5678.
- PSLVERR=1 with PREADY on an m1 write to addr 15 → m1_done=1, m1_err=1; m0 outputs unchanged.
- HRESET pulsed during ACCESS → PSEL=PENABLE=busy=0 immediately; no done pulse; after release, a pending tie grants m0 first.
- With GPIO_APB_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=16: PREADY held 0 → done+err after 16 ACCESS cycles, rdata=0; a subsequent normal transfer succeeds.
